// File: rtl/serial_write_queue_pkg.sv
// Shared definitions for the serial write queue: FSM state encoding and
// small helpers used to size ports and to build the last-chunk lane mask.
package serial_write_queue_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Width needed to hold a bit count in the range 0..buf_size.
   function automatic int count_width(input int buf_size);
      return $clog2(buf_size + 1);
   endfunction

   // Physical level of an undriven output line.
   function automatic logic idle_level(input bit active_low);
      return active_low;
   endfunction

   // True when a lane carries a real bit in a chunk with 'remain' bits left.
   // MSB-first packs valid bits into the top lanes, LSB-first into the bottom.
   function automatic logic lane_valid(input int lane, input int lanes,
                                       input int remain, input bit lsb_first);
      if (remain >= lanes) return 1'b1;
      if (lsb_first) return lane < remain;
      return lane >= lanes - remain;
   endfunction

endpackage

// File: rtl/serial_write_queue_fifo.sv
// Synchronous FIFO with registered full/empty flags and wrap-bit pointers.
// The head entry is presented combinationally on rd_data (show-ahead).
module sync_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int PW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr_nxt;
   logic [PW-1:0]    rd_ptr_nxt;
   logic             do_wr;
   logic             do_rd;

   assign do_wr      = wr_en && !full && !clear;
   assign do_rd      = rd_en && !empty && !clear;
   assign wr_ptr_nxt = wr_ptr + PW'(do_wr);
   assign rd_ptr_nxt = rd_ptr + PW'(do_rd);
   assign rd_data    = mem[rd_ptr[AW-1:0]];

   // Storage array written on accepted pushes.
   // NOTE: the array has no reset; the flags guard every read so stale
   // contents are never observed, and an unreset array can map onto RAM.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   // Pointer and flag update; flags are computed from the next pointers so
   // they are registered rather than decoded after the clock edge.
   // NOTE: state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
         empty  <= (wr_ptr_nxt == rd_ptr_nxt);
         full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                   (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
      end
   end

endmodule

// File: rtl/serial_write_queue.sv
// Queued multi-lane serial writer: words with a bit count are queued and
// shifted out LANES bits per write strobe, back-to-back across words.
module serial_write_queue
   import serial_write_queue_pkg::*;
#(
   parameter int  BUF_SIZE   = 8,
   parameter int  DEPTH      = 4,
   parameter int  LANES      = 1,
   parameter bit  LSB_FIRST  = 1'b0,
   parameter bit  ACTIVE_LOW = 1'b0,
   localparam int CW         = count_width(BUF_SIZE)
) (
   input  logic                sys_clk,
   input  logic                rst,
   input  logic                push,
   input  logic [BUF_SIZE-1:0] data_in,
   input  logic [CW-1:0]       write_count,
   input  logic                flush,
   input  logic                write_sig,
   output logic [LANES-1:0]    out_line,
   output logic                full,
   output logic                empty,
   output logic                busy,
   output logic                done_sig,
   output logic                overflow,
   output logic                underrun
);

   localparam int              EW       = BUF_SIZE + CW;
   localparam logic [LANES-1:0] IDLE_OUT = {LANES{idle_level(ACTIVE_LOW)}};

   state_t              state;
   logic [BUF_SIZE-1:0] shift_data;
   logic [CW-1:0]       remain;
   logic [CW-1:0]       count_clamped;
   logic [EW-1:0]       fifo_rdata;
   logic [BUF_SIZE-1:0] head_data;
   logic [CW-1:0]       head_count;
   logic                fifo_wr;
   logic                fifo_rd;
   logic                last_chunk;
   logic [BUF_SIZE-1:0] shift_adv;
   logic [CW-1:0]       remain_adv;

   // Physical line value for the chunk at the head of a shifter image:
   // pick the earliest LANES bits, blank lanes past the word end, then invert.
   function automatic logic [LANES-1:0] drive(input logic [BUF_SIZE-1:0] d,
                                              input logic [CW-1:0] r);
      logic [LANES-1:0] c;
      logic [LANES-1:0] m;
      c = LSB_FIRST ? d[LANES-1:0] : d[BUF_SIZE-1 -: LANES];
      for (int i = 0; i < LANES; i++) m[i] = lane_valid(i, LANES, int'(r), LSB_FIRST);
      return (c & m) ^ IDLE_OUT;
   endfunction

   assign count_clamped = (write_count > CW'(BUF_SIZE)) ? CW'(BUF_SIZE) : write_count;
   assign fifo_wr       = push && !flush && (write_count != '0);
   assign last_chunk    = (remain <= CW'(LANES));
   assign fifo_rd       = !flush && !empty &&
                          ((state == ST_IDLE) ||
                           ((state == ST_SHIFT) && write_sig && last_chunk));
   assign {head_count, head_data} = fifo_rdata;
   assign shift_adv     = LSB_FIRST ? (shift_data >> LANES) : (shift_data << LANES);
   assign remain_adv    = remain - CW'(LANES);
   assign busy          = (state == ST_SHIFT);

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (sys_clk),
      .rst_n   (rst),
      .clear   (flush),
      .wr_en   (fifo_wr),
      .wr_data ({count_clamped, data_in}),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rdata),
      .full    (full),
      .empty   (empty)
   );

   // Load/shift FSM; out_line is registered from the post-edge shifter image
   // so a strobe changes the line on the same edge it is sampled.
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         shift_data <= '0;
         remain     <= '0;
         out_line   <= IDLE_OUT;
         done_sig   <= 1'b0;
         overflow   <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         done_sig <= 1'b0;
         overflow <= push && full && !flush;
         underrun <= write_sig && (state == ST_IDLE);
         if (flush) begin
            state      <= ST_IDLE;
            shift_data <= '0;
            remain     <= '0;
            out_line   <= IDLE_OUT;
         end else begin
            case (state)
               ST_IDLE: begin
                  out_line <= IDLE_OUT;
                  if (!empty) begin
                     shift_data <= head_data;
                     remain     <= head_count;
                     state      <= ST_SHIFT;
                  end
               end
               ST_SHIFT: begin
                  if (!write_sig) begin
                     out_line <= drive(shift_data, remain);
                  end else if (!last_chunk) begin
                     shift_data <= shift_adv;
                     remain     <= remain_adv;
                     out_line   <= drive(shift_adv, remain_adv);
                  end else begin
                     done_sig <= 1'b1;
                     if (!empty) begin
                        shift_data <= head_data;
                        remain     <= head_count;
                        out_line   <= drive(head_data, head_count);
                     end else begin
                        state      <= ST_IDLE;
                        shift_data <= '0;
                        remain     <= '0;
                        out_line   <= IDLE_OUT;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_write_queue.sv
// Directed bench: three instances (1-lane MSB, 4-lane MSB, 1-lane LSB
// active-low) share stimulus; each scenario checks one instance.
module tb_serial_write_queue;

   logic       sys_clk = 1'b0;
   logic       rst = 1'b0;
   logic       push = 1'b0;
   logic [7:0] data_in = '0;
   logic [3:0] write_count = '0;
   logic       flush = 1'b0;
   logic       write_sig = 1'b0;

   logic [0:0] a_out;  logic a_full, a_empty, a_busy, a_done, a_ovf, a_und;
   logic [3:0] b_out;  logic b_full, b_empty, b_busy, b_done, b_ovf, b_und;
   logic [0:0] c_out;  logic c_full, c_empty, c_busy, c_done, c_ovf, c_und;

   int n_checks = 0;
   int n_errors = 0;

   always #5 sys_clk = ~sys_clk;

   serial_write_queue #(.BUF_SIZE(8), .DEPTH(4), .LANES(1), .LSB_FIRST(1'b0), .ACTIVE_LOW(1'b0)) dut_a (
      .sys_clk(sys_clk), .rst(rst), .push(push), .data_in(data_in), .write_count(write_count),
      .flush(flush), .write_sig(write_sig), .out_line(a_out), .full(a_full), .empty(a_empty),
      .busy(a_busy), .done_sig(a_done), .overflow(a_ovf), .underrun(a_und));

   serial_write_queue #(.BUF_SIZE(8), .DEPTH(4), .LANES(4), .LSB_FIRST(1'b0), .ACTIVE_LOW(1'b0)) dut_b (
      .sys_clk(sys_clk), .rst(rst), .push(push), .data_in(data_in), .write_count(write_count),
      .flush(flush), .write_sig(write_sig), .out_line(b_out), .full(b_full), .empty(b_empty),
      .busy(b_busy), .done_sig(b_done), .overflow(b_ovf), .underrun(b_und));

   serial_write_queue #(.BUF_SIZE(8), .DEPTH(4), .LANES(1), .LSB_FIRST(1'b1), .ACTIVE_LOW(1'b1)) dut_c (
      .sys_clk(sys_clk), .rst(rst), .push(push), .data_in(data_in), .write_count(write_count),
      .flush(flush), .write_sig(write_sig), .out_line(c_out), .full(c_full), .empty(c_empty),
      .busy(c_busy), .done_sig(c_done), .overflow(c_ovf), .underrun(c_und));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_push(input logic [7:0] d, input logic [3:0] c);
      push = 1'b1; data_in = d; write_count = c;
      tick();
      push = 1'b0;
   endtask

   task automatic strobe();
      write_sig = 1'b1;
      tick();
      write_sig = 1'b0;
   endtask

   task automatic flush_all();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
   endtask

   initial begin
      logic [13:0] pat14;
      logic [7:0]  pat8;
      logic [3:0]  pat4;

      // Reset state of all three instances
      tick(); tick();
      check("rst_a_out", a_out, 0);  check("rst_b_out", b_out, 0);  check("rst_c_out", c_out, 1);
      check("rst_a_flags", {a_full, a_empty, a_busy, a_done, a_ovf, a_und}, 6'b010000);
      check("rst_b_flags", {b_full, b_empty, b_busy, b_done, b_ovf, b_und}, 6'b010000);
      check("rst_c_flags", {c_full, c_empty, c_busy, c_done, c_ovf, c_und}, 6'b010000);
      rst = 1'b1;
      tick();

      // 1: single MSB-first word, first chunk two edges after push
      flush_all();
      pat8 = 8'h9C;
      do_push(8'h9C, 4'd8);
      check("t1_idle_after_push", a_out, 0);
      tick();
      check("t1_busy_on_load", a_busy, 1);
      tick();
      for (int k = 0; k < 8; k++) begin
         check("t1_bit", a_out, pat8[7-k]);
         check("t1_no_done", a_done, 0);
         strobe();
      end
      check("t1_done", a_done, 1);
      check("t1_idle_out", a_out, 0);
      check("t1_not_busy", a_busy, 0);
      tick();
      check("t1_done_cleared", a_done, 0);

      // 2: two words back-to-back, no idle gap
      pat14 = 14'b10011100111100;
      do_push(8'h9C, 4'd8);
      do_push(8'hF0, 4'd6);
      tick();
      for (int k = 0; k < 14; k++) begin
         check("t2_bit", a_out, pat14[13-k]);
         strobe();
         check("t2_done", a_done, (k == 7 || k == 13) ? 1 : 0);
         check("t2_busy", a_busy, (k == 13) ? 0 : 1);
      end

      // 3: four lanes, partial last chunk masked
      flush_all();
      do_push(8'hA5, 4'd8);
      tick(); tick();
      check("t3_chunk0", b_out, 4'hA);
      strobe();
      check("t3_chunk1", b_out, 4'h5);
      check("t3_no_done", b_done, 0);
      strobe();
      check("t3_done", b_done, 1);
      check("t3_idle", b_out, 4'h0);
      do_push(8'hE0, 4'd3);
      tick(); tick();
      check("t3_masked", b_out, 4'hE);
      strobe();
      check("t3_done2", b_done, 1);
      check("t3_idle2", b_out, 4'h0);

      // 4: LSB-first, active-low line
      flush_all();
      check("t4_idle_before", c_out, 1);
      pat4 = 4'b0101;
      do_push(8'h05, 4'd4);
      tick();
      check("t4_idle_load", c_out, 1);
      tick();
      for (int k = 0; k < 4; k++) begin
         check("t4_bit", c_out, pat4[3-k]);
         strobe();
      end
      check("t4_done", c_done, 1);
      check("t4_idle_after", c_out, 1);

      // Count clamp (15 -> 8) and zero-count push ignored
      flush_all();
      do_push(8'h55, 4'd0);
      tick(); tick();
      check("zero_count_empty", a_empty, 1);
      check("zero_count_idle", a_busy, 0);
      pat8 = 8'hA5;
      do_push(8'hA5, 4'd15);
      tick(); tick();
      for (int k = 0; k < 8; k++) begin
         check("clamp_bit", a_out, pat8[7-k]);
         check("clamp_no_done", a_done, 0);
         strobe();
      end
      check("clamp_done", a_done, 1);

      // 5: capacity DEPTH+1, overflow on the sixth push, then flush
      flush_all();
      push = 1'b1; write_count = 4'd8;
      for (int i = 0; i < 6; i++) begin
         data_in = 8'(i + 1);
         tick();
         check("t5_full", a_full, (i >= 4) ? 1 : 0);
         check("t5_ovf", a_ovf, (i == 5) ? 1 : 0);
      end
      push = 1'b0;
      tick();
      check("t5_ovf_pulse", a_ovf, 0);
      check("t5_busy", a_busy, 1);
      check("t5_not_empty", a_empty, 0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("t5_flush_empty", a_empty, 1);
      check("t5_flush_full", a_full, 0);
      check("t5_flush_busy", a_busy, 0);
      check("t5_flush_out", a_out, 0);
      check("t5_flush_done", a_done, 0);

      // 6: asynchronous reset mid-word, then underrun
      tick();
      do_push(8'h9C, 4'd8);
      tick(); tick();
      strobe(); strobe(); strobe();
      check("t6_mid_bit", a_out, 1);
      #2 rst = 1'b0;
      #1;
      check("t6_async_out", a_out, 0);
      check("t6_async_busy", a_busy, 0);
      check("t6_async_empty", a_empty, 1);
      check("t6_async_c_out", c_out, 1);
      tick();
      rst = 1'b1;
      tick();
      strobe();
      check("t6_underrun", a_und, 1);
      check("t6_out_unchanged", a_out, 0);
      tick();
      check("t6_underrun_clear", a_und, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
